// File: rtl/rgb_to_hsv.sv
// RGB565 -> HSV converter: expands channels to 8 bits, finds max/min, then runs two
// lockstep restoring dividers for saturation and hue offset before a final hue wrap.
module rgb_to_hsv #(
  parameter logic BYPASS_GREY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rgb,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [8:0]  h,
  output logic [7:0]  s,
  output logic [7:0]  v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid holds with stable h/s/v until out_ready.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_rgb;
  logic [3:0]  r_cnt;
  logic [7:0]  r_max;
  logic [8:0]  r_base;
  logic        r_neg;
  logic        r_grey;
  logic [15:0] r_num_s, r_num_h;
  logic [7:0]  r_div_s, r_div_h;
  logic [7:0]  r_rem_s, r_rem_h;
  logic [7:0]  r_q_s, r_q_h;
  logic [8:0]  r_h;
  logic [7:0]  r_s, r_v;
  logic        r_out_valid;

  logic [7:0]  w_r8, w_g8, w_b8;
  logic [7:0]  w_max, w_min, w_delta, w_absdiff;
  logic [8:0]  w_diff, w_base;
  logic        w_neg, w_grey;
  logic [15:0] w_ns, w_nh;
  logic [8:0]  w_sh_s, w_sh_h;
  logic        w_ge_s, w_ge_h;
  logic [7:0]  w_sub_s, w_sub_h;
  logic [7:0]  w_qs, w_qh;
  logic [8:0]  w_hue;

  assign w_r8 = {r_rgb[15:11], r_rgb[15:13]};
  assign w_g8 = {r_rgb[10:5],  r_rgb[10:9]};
  assign w_b8 = {r_rgb[4:0],   r_rgb[4:2]};

  // Dominant channel picks the hue sector; ties resolve r, then g, then b.
  always_comb begin
    w_max  = w_b8;
    w_diff = {1'b0, w_r8} - {1'b0, w_g8};
    w_base = 9'd240;
    if (w_r8 >= w_g8 && w_r8 >= w_b8) begin
      w_max  = w_r8;
      w_diff = {1'b0, w_g8} - {1'b0, w_b8};
      w_base = 9'd0;
    end else if (w_g8 >= w_b8) begin
      w_max  = w_g8;
      w_diff = {1'b0, w_b8} - {1'b0, w_r8};
      w_base = 9'd120;
    end
    w_min = w_r8;
    if (w_g8 < w_min) w_min = w_g8;
    if (w_b8 < w_min) w_min = w_b8;
  end

  assign w_delta   = w_max - w_min;
  assign w_neg     = w_diff[8];
  assign w_absdiff = w_neg ? (8'd0 - w_diff[7:0]) : w_diff[7:0];
  assign w_grey    = (w_delta == 8'd0);
  assign w_ns      = {w_delta, 8'd0} - {8'd0, w_delta};
  assign w_nh      = {2'd0, w_absdiff, 6'd0} - {6'd0, w_absdiff, 2'd0};

  // Remainder stays below the divisor, so 8 bits hold it; the shifted value needs 9.
  assign w_sh_s  = {r_rem_s, r_num_s[15]};
  assign w_sh_h  = {r_rem_h, r_num_h[15]};
  assign w_ge_s  = (w_sh_s >= {1'b0, r_div_s});
  assign w_ge_h  = (w_sh_h >= {1'b0, r_div_h});
  assign w_sub_s = w_sh_s[7:0] - r_div_s;
  assign w_sub_h = w_sh_h[7:0] - r_div_h;

  assign w_qs = r_grey ? 8'd0 : r_q_s;
  assign w_qh = r_grey ? 8'd0 : r_q_h;

  always_comb begin
    w_hue = r_base + {1'b0, w_qh};
    if (r_neg) begin
      if (r_base < {1'b0, w_qh}) w_hue = r_base + 9'd360 - {1'b0, w_qh};
      else                       w_hue = r_base - {1'b0, w_qh};
    end
    if (w_hue == 9'd360) w_hue = 9'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rgb       <= 16'd0;
      r_cnt       <= 4'd0;
      r_max       <= 8'd0;
      r_base      <= 9'd0;
      r_neg       <= 1'b0;
      r_grey      <= 1'b0;
      r_num_s     <= 16'd0;
      r_num_h     <= 16'd0;
      r_div_s     <= 8'd1;
      r_div_h     <= 8'd1;
      r_rem_s     <= 8'd0;
      r_rem_h     <= 8'd0;
      r_q_s       <= 8'd0;
      r_q_h       <= 8'd0;
      r_h         <= 9'd0;
      r_s         <= 8'd0;
      r_v         <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rgb   <= rgb;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_max   <= w_max;
          r_base  <= w_base;
          r_neg   <= w_neg;
          r_grey  <= w_grey;
          r_cnt   <= 4'd0;
          r_rem_s <= 8'd0;
          r_rem_h <= 8'd0;
          r_q_s   <= 8'd0;
          r_q_h   <= 8'd0;
          // Grey pixels feed 0/1 so the dividers never see a zero divisor.
          r_num_s <= w_grey ? 16'd0 : w_ns;
          r_num_h <= w_grey ? 16'd0 : w_nh;
          r_div_s <= w_grey ? 8'd1 : w_max;
          r_div_h <= w_grey ? 8'd1 : w_delta;
          r_state <= (w_grey && BYPASS_GREY) ? S_FIN : S_DIV;
        end
        S_DIV: begin
          r_rem_s <= w_ge_s ? w_sub_s : w_sh_s[7:0];
          r_rem_h <= w_ge_h ? w_sub_h : w_sh_h[7:0];
          r_q_s   <= {r_q_s[6:0], w_ge_s};
          r_q_h   <= {r_q_h[6:0], w_ge_h};
          r_num_s <= {r_num_s[14:0], 1'b0};
          r_num_h <= {r_num_h[14:0], 1'b0};
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_FIN;
        end
        S_FIN: begin
          r_h         <= w_hue;
          r_s         <= w_qs;
          r_v         <= r_max;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign h         = r_h;
  assign s         = r_s;
  assign v         = r_v;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rgb_to_hsv.sv
// Bench for rgb_to_hsv: directed vector table, backpressure and reset sequences,
// a BYPASS_GREY=0 instance, and random pixels against an arithmetic HSV model.
module tb_rgb_to_hsv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rgb = 16'd0;
  logic        in_valid = 1'b0, in_valid0 = 1'b0;
  logic        out_ready = 1'b0, out_ready0 = 1'b0;
  logic        in_ready, in_ready0;
  logic        out_valid, out_valid0;
  logic [8:0]  h, h0;
  logic [7:0]  s, s0, v, v0;
  logic [2:0]  dbg_state, dbg_state0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [24:0] exp_q[$];

  typedef struct {
    logic [15:0] px;
    int          eh, es, ev, lat;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  rgb_to_hsv #(.BYPASS_GREY(1'b1)) dut (
    .clk(clk), .rst(rst), .rgb(rgb), .in_valid(in_valid), .in_ready(in_ready),
    .h(h), .s(s), .v(v), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  rgb_to_hsv #(.BYPASS_GREY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rgb(rgb), .in_valid(in_valid0), .in_ready(in_ready0),
    .h(h0), .s(s0), .v(v0), .out_valid(out_valid0), .out_ready(out_ready0),
    .dbg_state(dbg_state0)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // HSV straight from the colour definitions using plain integer arithmetic.
  function automatic logic [24:0] ref_hsv(input logic [15:0] px);
    int r, g, b, mx, mn, d, hh, ss, q, base, df, ad;
    r  = int'(px[15:11]) * 8 + int'(px[15:11]) / 4;
    g  = int'(px[10:5])  * 4 + int'(px[10:5])  / 16;
    b  = int'(px[4:0])   * 8 + int'(px[4:0])   / 4;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d  = mx - mn;
    if (d == 0) begin
      hh = 0; ss = 0;
    end else begin
      ss = (255 * d) / mx;
      if (r == mx)      begin base = 0;   df = g - b; end
      else if (g == mx) begin base = 120; df = b - r; end
      else              begin base = 240; df = r - g; end
      ad = (df < 0) ? -df : df;
      q  = (60 * ad) / d;
      hh = (df < 0) ? base - q : base + q;
      if (hh < 0) hh += 360;
      if (hh == 360) hh = 0;
    end
    return {9'(hh), 8'(ss), 8'(mx)};
  endfunction

  // Called #1 after a rising edge; accepts px on the next edge and waits for the result.
  task automatic run_px(input logic [15:0] px, input bit on0,
                        output int oh, output int os, output int ov, output int lat);
    lat = -1; oh = -1; os = -1; ov = -1;
    chk("in_ready_before", on0 ? in_ready0 : in_ready, 1);
    rgb = px;
    if (on0) in_valid0 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (on0 ? out_valid0 : out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    oh = on0 ? int'(h0) : int'(h);
    os = on0 ? int'(s0) : int'(s);
    ov = on0 ? int'(v0) : int'(v);
    if (on0) out_ready0 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0; out_ready = 1'b0;
    chk("out_valid_after_take", on0 ? out_valid0 : out_valid, 0);
    chk("in_ready_after_take", on0 ? in_ready0 : in_ready, 1);
  endtask

  initial begin
    int oh, os, ov, lat;
    logic [24:0] e;
    logic [15:0] px;

    tbl[0] = '{16'hF800, 0,   255, 255, 18};
    tbl[1] = '{16'h07E0, 120, 255, 255, 18};
    tbl[2] = '{16'h001F, 240, 255, 255, 18};
    tbl[3] = '{16'hFFE0, 60,  255, 255, 18};
    tbl[4] = '{16'hF81F, 300, 255, 255, 18};
    tbl[5] = '{16'h0000, 0,   0,   0,   2};
    tbl[6] = '{16'hFFFF, 0,   0,   255, 2};
    tbl[7] = '{16'h8410, 300, 3,   132, 18};

    // Clock/reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_h", h, 0);
    chk("rst_s", s, 0);
    chk("rst_v", v, 0);
    chk("rst_out_valid0", out_valid0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_px(tbl[i].px, 1'b0, oh, os, ov, lat);
      chk($sformatf("tbl%0d_h", i), oh, tbl[i].eh);
      chk($sformatf("tbl%0d_s", i), os, tbl[i].es);
      chk($sformatf("tbl%0d_v", i), ov, tbl[i].ev);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
    end

    // Fixed-latency instance: grey still takes the full path
    run_px(16'hFFFF, 1'b1, oh, os, ov, lat);
    chk("nb_white_h", oh, 0); chk("nb_white_s", os, 0);
    chk("nb_white_v", ov, 255); chk("nb_white_lat", lat, 18);
    run_px(16'h0000, 1'b1, oh, os, ov, lat);
    chk("nb_black_h", oh, 0); chk("nb_black_s", os, 0);
    chk("nb_black_v", ov, 0); chk("nb_black_lat", lat, 18);
    run_px(16'hF800, 1'b1, oh, os, ov, lat);
    chk("nb_red_h", oh, 0); chk("nb_red_s", os, 255);
    chk("nb_red_v", ov, 255); chk("nb_red_lat", lat, 18);

    // Backpressure: result held, busy input pulses ignored
    rgb = 16'h07E0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    chk("bp_lat", lat, 18);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      rgb = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_h", h, 120);
      chk("bp_s", s, 255);
      chk("bp_v", v, 255);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_queued_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);

    // Reset in the middle of the divide phase
    rgb = 16'hF800; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_h", h, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_v", v, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_px(16'h07E0, 1'b0, oh, os, ov, lat);
    chk("after_rst_h", oh, 120); chk("after_rst_s", os, 255);
    chk("after_rst_v", ov, 255); chk("after_rst_lat", lat, 18);

    // Random pixels vs. model through the expected queue
    for (int i = 0; i < 1200; i++) begin
      px = 16'($urandom_range(0, 65535));
      exp_q.push_back(ref_hsv(px));
      run_px(px, 1'b0, oh, os, ov, lat);
      e = exp_q.pop_front();
      chk($sformatf("rnd_%04h_h", px), oh, int'(e[24:16]));
      chk($sformatf("rnd_%04h_s", px), os, int'(e[15:8]));
      chk($sformatf("rnd_%04h_v", px), ov, int'(e[7:0]));
      chk($sformatf("rnd_%04h_lat", px), lat, (e[15:8] == 8'd0) ? 2 : 18);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
